multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main control state machine for the multicycle MIPS datapath. It sits directly upstream of the ALU control unit.
- Each cycle it decodes the instruction-register opcode and sequences fetch, decode, execute, memory and writeback. It drives every datapath enable plus the 3-bit alu_op consumed downstream.
- alu_op encoding: 000 = add, 001 = sub, 010 = R-type (use funct), 100 = or.
- A mem_ready handshake stalls memory-access states.

Parameters:
- OPC_W, 6, opcode field width.
- ST_W, 4, state register width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  instr[31:26] from the instruction register.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero (beq).
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  instruction register load.
- mem_to_reg  output  1  writeback select: 1 = MDR, 0 = ALUOut.
- reg_dst  output  1  1 = rd, 0 = rt.
- reg_write  output  1  register file write.
- alu_src_a  output  1  0 = PC, 1 = A.
- alu_src_b  output  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_op  output  3  to the ALU control unit.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- state  output  4  current state, for debug.

Behaviour:
- States: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, REXE = 6, RWB = 7, BEQ = 8, IMMEXE_ADD = 9, IMMEXE_OR = 10, IMMWB = 11, JUMP = 12. Codes 13–15 are unused and go to FETCH on the next edge.
- Reset (async, active-high): the state register becomes FETCH immediately. While reset is high, pc_write, pc_write_cond, ir_write, mem_write, reg_write and illegal_op are forced to 0. All other outputs take their FETCH values.
- Outputs are Moore, decoded from state, except that pc_write and ir_write in FETCH are qualified by mem_ready. Any signal not listed for a state is 0.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 000, pc_source = 00; pc_write = ir_write = mem_ready.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = 000 (branch target precompute).
  - Next state by opcode: 100011 (lw) or 101011 (sw) → MEMADR; 000000 → REXE; 000100 → BEQ; 001000 (addi) → IMMEXE_ADD; 001101 (ori) → IMMEXE_OR; 000010 (j) → JUMP; any other → FETCH with illegal_op = 1 for this one cycle.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 000. Goes to MEMRD for lw, MEMWR for sw (opcode held stable by the IR).
- MEMRD: mem_read = 1, i_or_d = 1. Waits for mem_ready, then MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Then FETCH.
- MEMWR: mem_write = 1, i_or_d = 1. Waits for mem_ready, then FETCH. mem_write stays high for the whole wait.
- REXE: alu_src_a = 1, alu_src_b = 00, alu_op = 010. Then RWB.
- RWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Then FETCH.
- BEQ: alu_src_a = 1, alu_src_b = 00, alu_op = 001, pc_write_cond = 1, pc_source = 01. Then FETCH.
- IMMEXE_ADD: alu_src_a = 1, alu_src_b = 10, alu_op = 000. Then IMMWB.
- IMMEXE_OR: same as IMMEXE_ADD except alu_op = 100. Then IMMWB.
- IMMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Then FETCH.
- JUMP: pc_write = 1, pc_source = 10. Then FETCH.
- Instruction latency with mem_ready always 1:
  - lw: 5 cycles.
  - sw, R-type, addi, ori: 4 cycles.
  - beq, j: 3 cycles.
  - Each mem_ready = 0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Reset asserted mid-instruction aborts the instruction. No write enable may glitch high during or after the reset edge. After release, the first cycle is FETCH.
- opcode is sampled only in DECODE and MEMADR; changes at other times have no effect.

Test Plan:
- Reset asserted in MEMWR with mem_write = 1 → state = 0 and mem_write = 0 asynchronously. After release, FETCH with mem_read = 1, alu_src_b = 01.
- lw (100011), mem_ready = 1 → states 0, 1, 2, 3, 4, 0. alu_op = 000 in MEMADR. MEMWB has reg_write = 1, mem_to_reg = 1. Exactly 5 cycles.
- R-type (000000) then ori (001101) → REXE alu_op = 010, RWB reg_dst = 1. Then IMMEXE_OR alu_op = 100, IMMWB reg_dst = 0, reg_write = 1.
- sw with mem_ready = 0 for 3 cycles in MEMWR → mem_write held high for 4 cycles. FETCH follows the cycle mem_ready = 1. reg_write never asserted.
- FETCH with mem_ready = 0 for 2 cycles → pc_write = ir_write = 0 for those cycles, 1 in the ready cycle, then DECODE.
- opcode 111111 in DECODE → illegal_op = 1 for exactly 1 cycle, next state FETCH, no write enables. beq (000100) → BEQ with alu_op = 001, pc_write_cond = 1, pc_source = 01.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and drives every datapath enable plus the alu_op field.
module multicycle_control_fsm #(
    parameter int OPC_W = 6,
    parameter int ST_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [2:0]       alu_op,
    output logic             illegal_op,
    output logic [ST_W-1:0]  state
);

    localparam logic [ST_W-1:0] S_FETCH      = 4'd0;
    localparam logic [ST_W-1:0] S_DECODE     = 4'd1;
    localparam logic [ST_W-1:0] S_MEMADR     = 4'd2;
    localparam logic [ST_W-1:0] S_MEMRD      = 4'd3;
    localparam logic [ST_W-1:0] S_MEMWB      = 4'd4;
    localparam logic [ST_W-1:0] S_MEMWR      = 4'd5;
    localparam logic [ST_W-1:0] S_REXE       = 4'd6;
    localparam logic [ST_W-1:0] S_RWB        = 4'd7;
    localparam logic [ST_W-1:0] S_BEQ        = 4'd8;
    localparam logic [ST_W-1:0] S_IMMEXE_ADD = 4'd9;
    localparam logic [ST_W-1:0] S_IMMEXE_OR  = 4'd10;
    localparam logic [ST_W-1:0] S_IMMWB      = 4'd11;
    localparam logic [ST_W-1:0] S_JUMP       = 4'd12;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_next;
    logic            w_pc_write;
    logic            w_pc_write_cond;
    logic            w_mem_write;
    logic            w_ir_write;
    logic            w_reg_write;
    logic            w_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Handshake: a memory access state holds its request (mem_read/mem_write) for
    // every cycle mem_ready is low; the access completes in the cycle mem_ready is high.
    always_comb begin
        w_next          = S_FETCH;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_illegal       = 1'b0;
        i_or_d          = 1'b0;
        mem_read        = 1'b0;
        mem_to_reg      = 1'b0;
        reg_dst         = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        pc_source       = 2'b00;
        alu_op          = 3'b000;
        case (r_state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                w_pc_write = mem_ready;
                w_ir_write = mem_ready;
                w_next     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_REXE;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_ADDI:      w_next = S_IMMEXE_ADD;
                    OP_ORI:       w_next = S_IMMEXE_OR;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                w_next   = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                i_or_d      = 1'b1;
                w_next      = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_REXE: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
                w_next    = S_RWB;
            end
            S_RWB: begin
                w_reg_write = 1'b1;
                reg_dst     = 1'b1;
            end
            S_BEQ: begin
                alu_src_a       = 1'b1;
                alu_op          = 3'b001;
                w_pc_write_cond = 1'b1;
                pc_source       = 2'b01;
            end
            S_IMMEXE_ADD: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_IMMWB;
            end
            S_IMMEXE_OR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b100;
                w_next    = S_IMMWB;
            end
            S_IMMWB: w_reg_write = 1'b1;
            S_JUMP: begin
                w_pc_write = 1'b1;
                pc_source  = 2'b10;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset gates the write enables directly so none can pulse while the state register clears.
    assign pc_write      = w_pc_write      & ~reset;
    assign pc_write_cond = w_pc_write_cond & ~reset;
    assign mem_write     = w_mem_write     & ~reset;
    assign ir_write      = w_ir_write      & ~reset;
    assign reg_write     = w_reg_write     & ~reset;
    assign illegal_op    = w_illegal       & ~reset;
    assign state         = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: each task walks one instruction scenario
// against an expected-state queue and hand-computed control values.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    int n_vec = 0;
    int n_bad = 0;
    logic [3:0] exp_q[$];

    multicycle_control_fsm #(.OPC_W(6), .ST_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic test_reset();
        reset = 1'b1; opcode = 6'b000000; mem_ready = 1'b1;
        #1;
        n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state); end
        n_vec++; if ({pc_write, ir_write, reg_write, mem_write, pc_write_cond, illegal_op} !== 6'b0) begin
            n_bad++; $display("FAIL rst_writes: got %b want 000000", {pc_write, ir_write, reg_write, mem_write, pc_write_cond, illegal_op}); end
        n_vec++; if ({mem_read, alu_src_b, i_or_d, alu_src_a} !== 5'b10100) begin
            n_bad++; $display("FAIL rst_fetch_outs: got %b want 10100", {mem_read, alu_src_b, i_or_d, alu_src_a}); end
        repeat (2) @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL rst_release_state: got %0d want 0", state); end
        @(negedge clk);
    endtask

    task automatic test_lw();
        logic [3:0] exp_s;
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        opcode = 6'b100011; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            exp_s = exp_q.pop_front();
            n_vec++; if (state !== exp_s) begin n_bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_s); end
            if (i == 0) begin
                n_vec++; if ({pc_write, ir_write} !== 2'b11) begin n_bad++; $display("FAIL lw_fetch_pcir: got %b want 11", {pc_write, ir_write}); end
            end
            if (i == 2) begin
                n_vec++; if ({alu_op, alu_src_a, alu_src_b} !== 6'b000110) begin
                    n_bad++; $display("FAIL lw_memadr: got %b want 000110", {alu_op, alu_src_a, alu_src_b}); end
            end
            if (i == 3) begin
                n_vec++; if ({mem_read, i_or_d, reg_write} !== 3'b110) begin n_bad++; $display("FAIL lw_memrd: got %b want 110", {mem_read, i_or_d, reg_write}); end
            end
            if (i == 4) begin
                n_vec++; if ({reg_write, mem_to_reg, reg_dst} !== 3'b110) begin n_bad++; $display("FAIL lw_memwb: got %b want 110", {reg_write, mem_to_reg, reg_dst}); end
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL lw_latency: got %0d want 0 after 5 cycles", state); end
        @(negedge clk);
    endtask

    task automatic test_rtype_ori();
        logic [3:0] exp_s;
        exp_q = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd10, 4'd11};
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            // Opcode switches to ori during RWB; it must not disturb the R-type flow.
            opcode = (i < 3) ? 6'b000000 : 6'b001101;
            #1;
            exp_s = exp_q.pop_front();
            n_vec++; if (state !== exp_s) begin n_bad++; $display("FAIL rori_state[%0d]: got %0d want %0d", i, state, exp_s); end
            if (i == 2) begin
                n_vec++; if ({alu_op, alu_src_a, alu_src_b} !== 6'b010100) begin n_bad++; $display("FAIL rexe: got %b want 010100", {alu_op, alu_src_a, alu_src_b}); end
            end
            if (i == 3) begin
                n_vec++; if ({reg_write, reg_dst, mem_to_reg} !== 3'b110) begin n_bad++; $display("FAIL rwb: got %b want 110", {reg_write, reg_dst, mem_to_reg}); end
            end
            if (i == 6) begin
                n_vec++; if ({alu_op, alu_src_a, alu_src_b} !== 6'b100110) begin n_bad++; $display("FAIL ori_exe: got %b want 100110", {alu_op, alu_src_a, alu_src_b}); end
            end
            if (i == 7) begin
                n_vec++; if ({reg_write, reg_dst, mem_to_reg} !== 3'b100) begin n_bad++; $display("FAIL ori_wb: got %b want 100", {reg_write, reg_dst, mem_to_reg}); end
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL ori_return: got %0d want 0", state); end
        @(negedge clk);
    endtask

    task automatic test_sw_stall();
        logic [3:0] exp_s;
        logic [6:0] rdy_tab;
        int         n_mw;
        int         n_rw;
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        rdy_tab = 7'b1000111;  // bit i = mem_ready in cycle i
        n_mw = 0; n_rw = 0;
        opcode = 6'b101011;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy_tab[i];
            #1;
            exp_s = exp_q.pop_front();
            n_vec++; if (state !== exp_s) begin n_bad++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, exp_s); end
            if (mem_write === 1'b1) n_mw++;
            if (reg_write === 1'b1) n_rw++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL sw_return: got %0d want 0", state); end
        n_vec++; if (n_mw !== 4) begin n_bad++; $display("FAIL sw_mem_write_cycles: got %0d want 4", n_mw); end
        n_vec++; if (n_rw !== 0) begin n_bad++; $display("FAIL sw_reg_write: got %0d want 0", n_rw); end
        @(negedge clk);
    endtask

    task automatic test_fetch_stall_jump();
        logic [3:0] exp_s;
        logic [4:0] rdy_tab;
        exp_q = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd12};
        rdy_tab = 5'b11100;
        opcode = 6'b000010;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy_tab[i];
            #1;
            exp_s = exp_q.pop_front();
            n_vec++; if (state !== exp_s) begin n_bad++; $display("FAIL jst_state[%0d]: got %0d want %0d", i, state, exp_s); end
            if (i < 3) begin
                n_vec++; if ({pc_write, ir_write} !== {2{rdy_tab[i]}}) begin
                    n_bad++; $display("FAIL fetch_stall_pcir[%0d]: got %b want %b", i, {pc_write, ir_write}, {2{rdy_tab[i]}}); end
            end
            if (i == 4) begin
                n_vec++; if ({pc_write, pc_source} !== 3'b110) begin n_bad++; $display("FAIL jump: got %b want 110", {pc_write, pc_source}); end
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL jump_return: got %0d want 0", state); end
        @(negedge clk);
    endtask

    task automatic test_illegal_beq();
        logic [3:0] exp_s;
        int         n_ill;
        exp_q = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd8};
        n_ill = 0;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            opcode = (i < 2) ? 6'b111111 : 6'b000100;
            #1;
            exp_s = exp_q.pop_front();
            n_vec++; if (state !== exp_s) begin n_bad++; $display("FAIL ib_state[%0d]: got %0d want %0d", i, state, exp_s); end
            if (illegal_op === 1'b1) n_ill++;
            if (i == 1) begin
                n_vec++; if ({illegal_op, pc_write, pc_write_cond, ir_write, mem_write, reg_write} !== 6'b100000) begin
                    n_bad++; $display("FAIL illegal_decode: got %b want 100000", {illegal_op, pc_write, pc_write_cond, ir_write, mem_write, reg_write}); end
            end
            if (i == 4) begin
                n_vec++; if ({alu_op, pc_write_cond, pc_source, alu_src_a, alu_src_b} !== 9'b001101100) begin
                    n_bad++; $display("FAIL beq: got %b want 001101100", {alu_op, pc_write_cond, pc_source, alu_src_a, alu_src_b}); end
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        n_vec++; if (n_ill !== 1) begin n_bad++; $display("FAIL illegal_pulse_len: got %0d want 1", n_ill); end
        n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL beq_return: got %0d want 0", state); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        opcode = 6'b101011; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_vec++; if ({state, mem_write} !== 5'b01011) begin n_bad++; $display("FAIL abort_pre: got %b want 01011", {state, mem_write}); end
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if ({state, mem_write} !== 5'b00000) begin n_bad++; $display("FAIL abort_async: got %b want 00000", {state, mem_write}); end
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if ({state, pc_write, ir_write, reg_write} !== 7'b0) begin
            n_bad++; $display("FAIL abort_held: got %b want 0000000", {state, pc_write, ir_write, reg_write}); end
        reset = 1'b0;
        #1;
        n_vec++; if ({state, mem_read, alu_src_b, pc_write} !== 8'b00001011) begin
            n_bad++; $display("FAIL abort_release: got %b want 00001011", {state, mem_read, alu_src_b, pc_write}); end
        mem_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype_ori();
        test_sw_stall();
        test_fetch_stall_jump();
        test_illegal_beq();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
